// File: rtl/r3_bf_last_pkg.sv
// Shared constants for the 81-point radix-3 FFT datapath.
package r3_bf_last_pkg;

    localparam int unsigned NFFT      = 81;
    localparam int unsigned K         = 28378;
    localparam int unsigned K_FRAC    = 15;
    localparam int unsigned K_WIDTH   = K_FRAC + 1;
    localparam int unsigned WIDTH_DEF = 18;
    localparam int unsigned FCNT_W    = $clog2(NFFT);

    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2
    } phase_t;

endpackage

// File: rtl/r3_bf_last_butterfly.sv
// Combinational stride-1 radix-3 DIF butterfly, no twiddles, rounded sqrt(3)/2 scaling.
module r3_butterfly
    import r3_bf_last_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned OWIDTH = WIDTH + 2
) (
    input  logic signed [WIDTH-1:0]  a_re,
    input  logic signed [WIDTH-1:0]  a_im,
    input  logic signed [WIDTH-1:0]  b_re,
    input  logic signed [WIDTH-1:0]  b_im,
    input  logic signed [WIDTH-1:0]  c_re,
    input  logic signed [WIDTH-1:0]  c_im,
    output logic signed [OWIDTH-1:0] x0_re,
    output logic signed [OWIDTH-1:0] x0_im,
    output logic signed [OWIDTH-1:0] x1_re,
    output logic signed [OWIDTH-1:0] x1_im,
    output logic signed [OWIDTH-1:0] x2_re,
    output logic signed [OWIDTH-1:0] x2_im
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned PW = SW + K_WIDTH;
    localparam logic signed [PW-1:0] K_P   = PW'(K);
    localparam logic signed [PW-1:0] ROUND = PW'(1 << (K_FRAC - 1));

    logic signed [SW-1:0]     s_re, s_im, d_re, d_im, hs_re, hs_im;
    logic signed [PW-1:0]     p_re, p_im, r_re, r_im;
    logic signed [OWIDTH-1:0] kr_re, kr_im, m_re, m_im;

    always_comb begin
        s_re  = SW'(b_re) + SW'(c_re);
        s_im  = SW'(b_im) + SW'(c_im);
        d_re  = SW'(b_re) - SW'(c_re);
        d_im  = SW'(b_im) - SW'(c_im);
        hs_re = s_re >>> 1;
        hs_im = s_im >>> 1;
        // Round-half-up of K*d back to integer scale
        p_re  = PW'(d_re) * K_P;
        p_im  = PW'(d_im) * K_P;
        r_re  = (p_re + ROUND) >>> K_FRAC;
        r_im  = (p_im + ROUND) >>> K_FRAC;
        kr_re = OWIDTH'(r_re);
        kr_im = OWIDTH'(r_im);
        m_re  = OWIDTH'(a_re) - OWIDTH'(hs_re);
        m_im  = OWIDTH'(a_im) - OWIDTH'(hs_im);
        x0_re = OWIDTH'(a_re) + OWIDTH'(s_re);
        x0_im = OWIDTH'(a_im) + OWIDTH'(s_im);
        x1_re = m_re + kr_im;
        x1_im = m_im - kr_re;
        x2_re = m_re - kr_im;
        x2_im = m_im + kr_re;
    end

endmodule

// File: rtl/r3_bf_last.sv
// Final radix-3 stage of the 81-point FFT: triplet capture, butterfly and
// three-cycle output serialisation with frame-last marking.
module r3_bf_last
    import r3_bf_last_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned OWIDTH = WIDTH + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  di_re,
    input  logic signed [WIDTH-1:0]  di_im,
    input  logic                     di_en,
    output logic signed [OWIDTH-1:0] do_re,
    output logic signed [OWIDTH-1:0] do_im,
    output logic                     do_en,
    output logic                     do_last
);

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(NFFT - 1);

    phase_t                   phase;
    logic signed [WIDTH-1:0]  a_re, a_im, b_re, b_im;
    logic signed [OWIDTH-1:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im;
    logic signed [OWIDTH-1:0] p0_re, p0_im, p1_re, p1_im;
    logic [1:0]               pend;
    logic [FCNT_W-1:0]        fcnt;
    logic                     take_c;
    logic                     emit;
    logic signed [OWIDTH-1:0] nxt_re, nxt_im;

    r3_butterfly #(
        .WIDTH (WIDTH),
        .OWIDTH(OWIDTH)
    ) u_bf (
        .a_re (a_re),
        .a_im (a_im),
        .b_re (b_re),
        .b_im (b_im),
        .c_re (di_re),
        .c_im (di_im),
        .x0_re(x0_re),
        .x0_im(x0_im),
        .x1_re(x1_re),
        .x1_im(x1_im),
        .x2_re(x2_re),
        .x2_im(x2_im)
    );

    // Fresh X0 wins; otherwise drain the pending X1/X2 pair
    always_comb begin
        take_c = di_en && (phase == PH_C);
        emit   = 1'b0;
        nxt_re = '0;
        nxt_im = '0;
        if (take_c) begin
            emit   = 1'b1;
            nxt_re = x0_re;
            nxt_im = x0_im;
        end else if (pend != 2'd0) begin
            emit   = 1'b1;
            nxt_re = p0_re;
            nxt_im = p0_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_A;
            a_re    <= '0;
            a_im    <= '0;
            b_re    <= '0;
            b_im    <= '0;
            p0_re   <= '0;
            p0_im   <= '0;
            p1_re   <= '0;
            p1_im   <= '0;
            pend    <= 2'd0;
            fcnt    <= '0;
            do_re   <= '0;
            do_im   <= '0;
            do_en   <= 1'b0;
            do_last <= 1'b0;
        end else begin
            if (di_en) begin
                case (phase)
                    PH_A: begin
                        a_re  <= di_re;
                        a_im  <= di_im;
                        phase <= PH_B;
                    end
                    PH_B: begin
                        b_re  <= di_re;
                        b_im  <= di_im;
                        phase <= PH_C;
                    end
                    default: phase <= PH_A;
                endcase
            end

            if (take_c) begin
                p0_re <= x1_re;
                p0_im <= x1_im;
                p1_re <= x2_re;
                p1_im <= x2_im;
                pend  <= 2'd2;
            end else if (pend != 2'd0) begin
                p0_re <= p1_re;
                p0_im <= p1_im;
                p1_re <= '0;
                p1_im <= '0;
                pend  <= pend - 2'd1;
            end

            do_en   <= emit;
            do_re   <= nxt_re;
            do_im   <= nxt_im;
            do_last <= emit && (fcnt == FCNT_LAST);
            if (emit) begin
                fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_r3_bf_last.sv
// Randomised and directed checks of r3_bf_last against a queue-based reference.
module tb_r3_bf_last;

    localparam int unsigned W  = 18;
    localparam int unsigned OW = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 di_en;
    logic signed [W-1:0]  di_re, di_im;
    logic signed [OW-1:0] do_re, do_im;
    logic                 do_en, do_last;

    always #5 clk = ~clk;

    r3_bf_last #(
        .WIDTH (W),
        .OWIDTH(OW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .di_re  (di_re),
        .di_im  (di_im),
        .di_en  (di_en),
        .do_re  (do_re),
        .do_im  (do_im),
        .do_en  (do_en),
        .do_last(do_last)
    );

    typedef struct {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } cpx_t;

    cpx_t   exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     ph          = 0;
    int     ocnt        = 0;
    longint ar, ai, br, bi;
    bit     const_mode  = 1'b0;
    longint cx_re[3];
    longint cx_im[3];
    string  tag         = "";

    function automatic cpx_t mk(input longint re, input longint im);
        cpx_t v;
        v.re = OW'(re);
        v.im = OW'(im);
        return v;
    endfunction

    // Reference radix-3 triplet from the arithmetic definition
    task automatic push_model(input longint cr, input longint ci);
        longint k, sr, si, dr, dim, rr, ri, mr, mi;
        k   = 28378;
        sr  = br + cr;
        si  = bi + ci;
        dr  = br - cr;
        dim = bi - ci;
        rr  = (k * dr + 16384) >>> 15;
        ri  = (k * dim + 16384) >>> 15;
        mr  = ar - (sr >>> 1);
        mi  = ai - (si >>> 1);
        exp_q.push_back(mk(ar + sr, ai + si));
        exp_q.push_back(mk(mr + ri, mi - rr));
        exp_q.push_back(mk(mr - ri, mi + rr));
    endtask

    task automatic step(input bit r, input bit en,
                        input logic signed [W-1:0] re, input logic signed [W-1:0] im);
        cpx_t             e;
        logic [2*OW+1:0]  got, want;
        bit               e_en, e_last;
        rst   = r;
        di_en = en;
        di_re = re;
        di_im = im;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            ph   = 0;
            ocnt = 0;
        end else if (en) begin
            if (ph == 0) begin
                ar = longint'(re);
                ai = longint'(im);
            end else if (ph == 1) begin
                br = longint'(re);
                bi = longint'(im);
            end else if (const_mode) begin
                for (int i = 0; i < 3; i++) exp_q.push_back(mk(cx_re[i], cx_im[i]));
            end else begin
                push_model(longint'(re), longint'(im));
            end
            ph = (ph + 1) % 3;
        end
        #1;
        e_en   = 1'b0;
        e_last = 1'b0;
        e.re   = '0;
        e.im   = '0;
        if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            e_en   = 1'b1;
            e_last = (ocnt == 80);
            ocnt   = (ocnt + 1) % 81;
        end
        got  = {do_en, do_last, do_re, do_im};
        want = {e_en, e_last, e.re, e.im};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed en=%0b last=%0b re=%0d im=%0d, expected en=%0b last=%0b re=%0d im=%0d",
                   tag, do_en, do_last, do_re, do_im, e_en, e_last, e.re, e.im);
        end
    endtask

    function automatic logic signed [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0:       rnd = W'(-131072);
            1:       rnd = W'(131071);
            default: rnd = W'($urandom);
        endcase
    endfunction

    task automatic burst(input int n, input bit gappy);
        bit en;
        for (int i = 0; i < n; i++) begin
            en = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b0, en, rnd(), rnd());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst   = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        #3;

        tag = "reset";
        repeat (3) step(1'b1, 1'b0, '0, '0);
        tag = "idle";
        idle(2);

        const_mode = 1'b1;
        tag = "equal_trip";
        cx_re = '{3000, 0, 0};
        cx_im = '{0, 0, 0};
        repeat (3) step(1'b0, 1'b1, W'(1000), '0);

        tag = "impulse_b";
        cx_re = '{1000, -500, -500};
        cx_im = '{0, -866, 866};
        step(1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b1, W'(1000), '0);
        step(1'b0, 1'b1, '0, '0);

        tag = "neg_full";
        cx_re = '{-393216, 0, 0};
        cx_im = '{-393216, 0, 0};
        repeat (3) step(1'b0, 1'b1, W'(-131072), W'(-131072));
        const_mode = 1'b0;
        tag = "drain";
        idle(3);

        tag = "frame";
        step(1'b1, 1'b0, '0, '0);
        burst(81, 1'b0);
        idle(4);

        tag = "two_frames";
        burst(162, 1'b0);
        idle(4);

        tag = "mid_reset";
        burst(40, 1'b0);
        repeat (2) step(1'b1, 1'b1, rnd(), rnd());
        burst(81, 1'b0);
        idle(4);

        tag = "gaps";
        step(1'b1, 1'b0, '0, '0);
        burst(200, 1'b1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/r3_bf_last.md
R3_BF_LAST -- requirements
Module: r3_bf_last

Interface
REQ-001 Parameter WIDTH, default 18, SHALL set the signed two's-complement input sample width.
REQ-002 Parameter OWIDTH, default WIDTH+2, SHALL set the signed output width; the downstream reorder stage is instantiated with its WIDTH equal to OWIDTH.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 di_re, di_im  in  WIDTH each  signed input sample, real and imaginary parts.
REQ-007 di_en  in  1  input sample valid; one sample per cycle while high.
REQ-008 do_re, do_im  out  OWIDTH each  signed butterfly output sample, registered.
REQ-009 do_en  out  1  output sample valid, registered.
REQ-010 do_last  out  1  high with the 81st output of a frame, registered.

Function
REQ-011 The block SHALL implement the final stride-1 radix-3 DIF butterfly of the 81-point FFT; it SHALL apply no twiddle multiplication.
REQ-012 An input phase counter (0,1,2) SHALL advance only on di_en=1 cycles: phase 0 latches a, phase 1 latches b, phase 2 takes c from the input port and computes the triplet.
REQ-013 Arithmetic SHALL be as follows, with s=b+c and d=b-c computed at WIDTH+1 bits:
  - X0 = a+b+c.
  - X1.re = a.re - (s.re>>>1) + R(K*d.im); X1.im = a.im - (s.im>>>1) - R(K*d.re).
  - X2.re = a.re - (s.re>>>1) - R(K*d.im); X2.im = a.im - (s.im>>>1) + R(K*d.re).
REQ-014 K SHALL be 28378 (sqrt(3)/2 in unsigned Q0.15); R(p) = (p + 16384)>>>15; >>> is an arithmetic shift (floor); there SHALL be no saturation, because OWIDTH=WIDTH+2 cannot overflow.
REQ-015 X0 SHALL appear on do_re/do_im with do_en=1 in the cycle after c is accepted; X1 SHALL follow in the next cycle and X2 in the cycle after that. Latency from c to X0 is 1 cycle.
REQ-016 X1 and X2 SHALL be held in a two-entry pending register and drain on consecutive cycles regardless of di_en.
REQ-017 With a contiguous di_en burst of 81 samples starting at cycle t0, do_en SHALL be high continuously for cycles t0+3 .. t0+83.
REQ-018 A frame output counter (0..80) SHALL assert do_last with output 80 and then wrap to 0; the input phase likewise returns to 0 after 81 samples.
REQ-019 A di_en gap inside a triplet SHALL hold the phase and the latched samples and resume on the next di_en=1. The resulting output gap is legal here but breaks the downstream contiguity requirement; upstream guarantees gapless frames.
REQ-020 When do_en=0, do_re, do_im and do_last SHALL be 0.
REQ-021 A new triplet's phase 0 and phase 1 SHALL coincide with draining X1 and X2 of the previous triplet with no stall and no conflict.

Reset
REQ-022 rst=1 SHALL clear to 0 the phase counter, frame counter, pending registers, do_re, do_im, do_en and do_last on the next edge.
REQ-023 Reset mid-frame SHALL discard any partial triplet and pending outputs; the first sample accepted after reset is phase 0 of a new frame.
REQ-024 rst SHALL take priority over di_en in the same cycle.

Structure
REQ-025 A shared FFT package SHALL hold NFFT=81, K=28378, the K fraction width of 15, and the WIDTH default.
REQ-026 The butterfly arithmetic SHALL be a combinational sub-module r3_butterfly (inputs a, b, c; outputs X0, X1, X2). Sequencing, counters and output registers live in r3_bf_last.

Verification
REQ-027 Triplet (1000,1000,1000), imaginary parts 0 -> X0=(3000,0), X1=(0,0), X2=(0,0).
REQ-028 Triplet a=(0,0), b=(1000,0), c=(0,0) -> X0=(1000,0), X1=(-500,-866), X2=(-500,866).
REQ-029 All inputs -131072+j(-131072) -> X0=(-393216,-393216), X1=(0,0), X2=(0,0), with no wrap.
REQ-030 Contiguous 81-sample burst starting at t0 -> do_en high for exactly 81 cycles t0+3..t0+83, and do_last only at t0+83.
REQ-031 Two back-to-back frames -> 162 contiguous outputs, with do_last at outputs 81 and 162.
REQ-032 rst asserted after 40 inputs, then a fresh burst -> outputs are zero during reset, and the first post-reset output equals X0 of the new frame's first triplet.
